// File: rtl/clint_timer_pkg.sv
// Shared CLINT constants: bridge window base, register offsets, reset values,
// plus the byte-lane merge used by every writable register.
package clint_timer_pkg;

  localparam logic [15:0] CLINT_BASE         = 16'h0200;
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Lanes with we[i]=1 take the new byte, the rest keep the old one.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  we);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime prescaler: one-cycle tick every TICK_DIV running cycles, frozen by stop.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic stop,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign tick = !stop && (cnt == LAST);

  // Count 0..TICK_DIV-1 while running; wrap on the tick cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!stop) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor for one hart: msip, mtimecmp and mtime behind a
// byte-enable bus with one-cycle registered read data.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clint_en,
  input  logic [7:0]  clint_we,
  input  logic [63:0] clint_addr,
  input  logic [63:0] clint_wdata,
  output logic [63:0] clint_rdata,
  input  logic        time_stop,
  output logic        soft_irq,
  output logic        timer_irq
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tick;
  logic        wr_en;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_mtime;
  logic [63:0] rd_val;
  logic        unused_addr_bits;

  assign wr_en     = clint_en && (clint_we != 8'h00);
  assign sel_msip  = (clint_addr[15:3] == CLINT_MSIP_OFF[15:3]);
  assign sel_cmp   = (clint_addr[15:3] == CLINT_MTIMECMP_OFF[15:3]);
  assign sel_mtime = (clint_addr[15:3] == CLINT_MTIME_OFF[15:3]);

  // Only [15:3] is decoded; the bridge already matched the upper window.
  assign unused_addr_bits = ^{clint_addr[63:16], clint_addr[2:0]};

  clint_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .stop   (time_stop),
    .tick   (tick)
  );

  // Read mux over current register values (pre-update); unmapped reads give 0.
  always_comb begin
    rd_val = '0;
    if (sel_msip)       rd_val = {63'd0, msip};
    else if (sel_cmp)   rd_val = mtimecmp;
    else if (sel_mtime) rd_val = mtime;
  end

  // mtime: a software write wins over the tick increment in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtime <= '0;
    end else if (wr_en && sel_mtime) begin
      mtime <= byte_merge(mtime, clint_wdata, clint_we);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp and msip byte-lane writes; msip keeps only bit 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtimecmp <= CLINT_MTIMECMP_RST;
      msip     <= 1'b0;
    end else if (wr_en) begin
      if (sel_cmp)               mtimecmp <= byte_merge(mtimecmp, clint_wdata, clint_we);
      if (sel_msip && clint_we[0]) msip   <= clint_wdata[0];
    end
  end

  // Registered read data (writes return 0) and the registered timer compare.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clint_rdata <= '0;
      timer_irq   <= 1'b0;
    end else begin
      if (clint_en) clint_rdata <= wr_en ? 64'd0 : rd_val;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  assign soft_irq = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV=1 and 4) on a shared bus,
// compared every cycle against a register-level reference model.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [7:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stop;
  logic [63:0] rdata_a, rdata_b;
  logic        sirq_a, sirq_b, tirq_a, tirq_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = TICK_DIV 1, index 1 = TICK_DIV 4.
  int unsigned div [2] = '{1, 4};
  int unsigned run [2];
  logic [63:0] mt  [2];
  logic [63:0] mc  [2];
  logic [63:0] rdm [2];
  logic        ms  [2];
  logic        ti  [2];

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1)) dut_a (
    .clk(clk), .resetn(resetn), .clint_en(en), .clint_we(we),
    .clint_addr(addr), .clint_wdata(wdata), .clint_rdata(rdata_a),
    .time_stop(stop), .soft_irq(sirq_a), .timer_irq(tirq_a)
  );

  clint_timer #(.TICK_DIV(4)) dut_b (
    .clk(clk), .resetn(resetn), .clint_en(en), .clint_we(we),
    .clint_addr(addr), .clint_wdata(wdata), .clint_rdata(rdata_b),
    .time_stop(stop), .soft_irq(sirq_b), .timer_irq(tirq_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; mt[k] = 0; mc[k] = '1; rdm[k] = 0; ms[k] = 0; ti[k] = 0;
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] b);
    logic [63:0] m;
    m = 0;
    for (int i = 0; i < 8; i++) if (b[i]) m = m | (64'hFF << (8 * i));
    return m;
  endfunction

  // One rising edge of the abstract CLINT, using the bus values at that edge.
  task automatic model_edge(input int k);
    logic [63:0] old_t, old_c, m, rv;
    logic [15:0] off;
    logic        wr, tk;
    if (!resetn) return;
    old_t = mt[k]; old_c = mc[k];
    off = {addr[15:3], 3'b000};
    wr  = en && (we != 0);
    m   = lane_mask(we);
    tk  = !stop && ((run[k] % div[k]) == div[k] - 1);
    if (!stop) run[k]++;
    case (off)
      16'h0000: rv = {63'd0, ms[k]};
      16'h4000: rv = old_c;
      16'hBFF8: rv = old_t;
      default:  rv = 0;
    endcase
    if (en) rdm[k] = wr ? 64'd0 : rv;
    ti[k] = (old_t >= old_c);
    if (wr && off == 16'hBFF8) mt[k] = (old_t & ~m) | (wdata & m);
    else if (tk)               mt[k] = old_t + 1;
    if (wr && off == 16'h4000) mc[k] = (old_c & ~m) | (wdata & m);
    if (wr && off == 16'h0000 && we[0]) ms[k] = wdata[0];
  endtask

  task automatic check_outputs();
    chk("rdata_div1", rdata_a, rdm[0]);
    chk("rdata_div4", rdata_b, rdm[1]);
    chk("soft_irq_div1", {63'd0, sirq_a}, {63'd0, ms[0]});
    chk("soft_irq_div4", {63'd0, sirq_b}, {63'd0, ms[1]});
    chk("timer_irq_div1", {63'd0, tirq_a}, {63'd0, ti[0]});
    chk("timer_irq_div4", {63'd0, tirq_b}, {63'd0, ti[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    en = 0; we = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
    en = 1; we = w; addr = a; wdata = d;
    step();
    en = 0; we = 0;
  endtask

  initial begin
    resetn = 0; en = 0; we = 0; addr = 0; wdata = 0; stop = 0;
    model_reset();
    #12;
    chk("reset_rdata", rdata_a, 64'd0);
    chk("reset_tirq", {63'd0, tirq_b}, 64'd0);
    @(negedge clk);
    resetn = 1;

    // Idle count from reset.
    idle(10);
    bus(8'h00, 64'h0200_BFF8, 0);
    chk("idle10_mtime_div1", rdata_a, 64'd10);
    chk("idle10_soft", {63'd0, sirq_a}, 64'd0);

    // Compare crossing at 0x20, then drop by raising mtimecmp.
    bus(8'hFF, 64'h0200_4000, 64'h20);
    bus(8'hFF, 64'h0200_BFF8, 64'h0);
    idle(140);
    chk("cmp_hit_div4", {63'd0, tirq_b}, 64'd1);
    bus(8'hFF, 64'h0200_4000, '1);
    step();
    chk("cmp_drop_div4", {63'd0, tirq_b}, 64'd0);

    // Wrap of mtime against mtimecmp = 1.
    bus(8'hFF, 64'h0200_4000, 64'h1);
    bus(8'hFF, 64'h0200_BFF8, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 4; i++) bus(8'h00, 64'h0200_BFF8, 0);
    idle(3);

    // Partial write in a tick cycle (every cycle ticks at TICK_DIV 1).
    bus(8'hFF, 64'h0200_BFF8, 64'hAAAA_BBBB_0000_0000);
    bus(8'h0F, 64'h0200_BFF8, 64'h0000_0000_1234_5678);
    bus(8'h00, 64'h0200_BFF8, 0);
    chk("partial_write_div1", rdata_a, 64'hAAAA_BBBB_1234_5678);

    // msip and unmapped offsets.
    bus(8'hFF, 64'h0200_0000, 64'h3);
    chk("msip_set", {63'd0, sirq_a}, 64'd1);
    bus(8'h00, 64'h0200_0004, 0);
    chk("msip_read", rdata_a, 64'd1);
    bus(8'hFF, 64'h0200_0000, 64'h0);
    chk("msip_clr", {63'd0, sirq_b}, 64'd0);
    bus(8'h00, 64'h0200_8000, 0);
    chk("unmapped_read", rdata_a, 64'd0);
    bus(8'hFF, 64'h0200_8000, '1);
    bus(8'h00, 64'h0200_4000, 0);

    // Debug halt freezes mtime and prescaler.
    stop = 1;
    bus(8'h00, 64'h0200_BFF8, 0);
    idle(50);
    bus(8'h00, 64'h0200_BFF8, 0);
    stop = 0;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 4))
        0: a = 64'h0200_0000;
        1: a = 64'h0200_4000;
        2: a = 64'h0200_BFF8;
        3: a = {48'h0, 16'($urandom)};
        default: a = {$urandom, $urandom};
      endcase
      a[2:0] = 3'($urandom);
      en    = ($urandom_range(0, 9) < 7);
      we    = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      addr  = a;
      wdata = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {32'hFFFF_FFFF, $urandom};
      stop  = ($urandom_range(0, 9) == 0);
      step();
    end
    en = 0; we = 0; stop = 0;

    // Asynchronous reset mid-count.
    bus(8'h00, 64'h0200_BFF8, 0);
    idle(5);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #3;
    resetn = 0;
    model_reset();
    #1;
    chk("async_rdata_div1", rdata_a, 64'd0);
    chk("async_rdata_div4", rdata_b, 64'd0);
    chk("async_tirq", {63'd0, tirq_a}, 64'd0);
    idle(2);
    @(negedge clk);
    resetn = 1;
    bus(8'h00, 64'h0200_4000, 0);
    chk("post_reset_cmp", rdata_b, '1);
    bus(8'h00, 64'h0200_BFF8, 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor for a single hart; the slave on the bridge's clint port, decoded there as address window 0x0200_xxxx.
- Holds the RISC-V msip, mtime and mtimecmp registers behind a simple enable/byte-write-enable bus.
- Returns read data with a fixed one-cycle latency, matching the bridge's registered read-select.
- Drives the machine software interrupt and the machine timer interrupt into the core's CSR/trap logic.

Parameters:
- TICK_DIV, 1, core clock cycles per mtime increment; legal range 1..65535.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- clint_en  in  1  access strobe, valid for one cycle per access
- clint_we  in  8  byte write enables; all zero means read
- clint_addr  in  64  byte address; only bits [15:3] are decoded
- clint_wdata  in  64  write data, byte lane i = bits [8i+7:8i]
- clint_rdata  out  64  read data, registered
- time_stop  in  1  freezes mtime counting (debug halt)
- soft_irq  out  1  machine software interrupt pending (msip bit 0)
- timer_irq  out  1  machine timer interrupt pending

Behaviour:
- Reset: asynchronous on resetn low.
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - clint_rdata = 0, soft_irq = 0, timer_irq = 0.
- Register map, decoded on clint_addr[15:3]; clint_addr[2:0] ignored:
  - 0x0000 msip: only bit 0 is storage; bits 63:1 read 0 and ignore writes.
  - 0x4000 mtimecmp: 64-bit read/write.
  - 0xBFF8 mtime: 64-bit read/write.
  - Any other offset: reads return 0, writes are ignored with no error.
- Writes:
  - Occur when clint_en=1 and clint_we!=0.
  - Each byte lane with we[i]=1 takes wdata; lanes with we[i]=0 keep their value.
  - New register values are visible from the next cycle.
- Reads:
  - Occur when clint_en=1 and clint_we=0; clint_rdata is updated at the next rising edge (latency 1).
  - The value returned is the register value before that cycle's update, i.e. pre-increment mtime.
- clint_rdata update rules:
  - Write cycle: clint_rdata is loaded with 0.
  - clint_en=0: clint_rdata holds its previous value.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and asserts a one-cycle tick on wrap; with TICK_DIV=1, tick is asserted every cycle.
  - When time_stop=1, both the prescaler and mtime hold.
- mtime:
  - On tick, mtime <= mtime + 1, unsigned 64-bit; wraps from all-ones to 0.
  - A write to any byte of mtime in a tick cycle wins: the merged write value is loaded and the increment is dropped.
  - The prescaler is not reset by mtime writes.
- timer_irq:
  - A flop updated each cycle with (mtime >= mtimecmp), unsigned comparison on current register values.
  - Lags register changes by exactly one cycle.
  - Level-sensitive: it stays high until software raises mtimecmp above mtime or mtime wraps.
- soft_irq: a direct flop output of msip bit 0; asserts the cycle after the write.
- Simultaneous events:
  - Read and tick in the same cycle: the read returns the old mtime.
  - Write to mtimecmp in the same cycle as the compare: the compare uses the old mtimecmp, and the new value takes effect on the following cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, and no partial write survives.

Decomposition:
- Shared defines header clint_defs.vh:
  - CLINT_MSIP_OFF = 16'h0000, CLINT_MTIMECMP_OFF = 16'h4000, CLINT_MTIME_OFF = 16'hBFF8.
  - CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF.
- The bridge's CLINT base address (16'h0200) moves into the same header.
- Sub-module clint_tick_gen: the prescaler, with inputs clk, resetn, stop and output tick; parameter TICK_DIV.
- Byte-merge logic is a function, not a sub-module.

Test Plan:
- Reset then idle 10 cycles with TICK_DIV=1 -> reading 0xBFF8 returns 10 (±1 for read timing); timer_irq=0; soft_irq=0.
- Write mtimecmp=0x20 with we=8'hFF, TICK_DIV=4, mtime=0 -> timer_irq rises exactly one cycle after mtime reaches 0x20 (cycle ~128); writing mtimecmp=0xFFFF_FFFF_FFFF_FFFF drops it the next cycle.
- Write mtime=0xFFFF_FFFF_FFFF_FFFE with TICK_DIV=1 -> subsequent reads show ...FFFF, then 0x0 (wrap); timer_irq tracks the compare against mtimecmp=0x1.
- Partial write to mtime with we=8'h0F, wdata=0x1234_5678 while mtime=0xAAAA_BBBB_0000_0000 in a tick cycle -> mtime=0xAAAA_BBBB_1234_5678 and no increment that cycle.
- Write msip wdata=0x3 -> soft_irq=1 next cycle and a read returns 0x1; write 0 -> soft_irq=0; read at offset 0x8000 returns 0, and a write there changes nothing.
- time_stop=1 for 50 cycles -> mtime is unchanged; then deassert resetn asynchronously mid-count -> mtime=0, mtimecmp=all ones, clint_rdata=0 without waiting for a clock edge.
